// File: rtl/mac_vert_pkg.sv
// Shared types and width helpers for the vertical bit-column MAC.
// Optional saturation build: MAC_VERT_SAT_EN.
package mac_vert_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // {is_msb, is_skip_zero}
  typedef enum logic [1:0] {
    TS_ONES_FROM_ZEROS = 2'b00,
    TS_PSUM            = 2'b01,
    TS_MSB_ZEROS       = 2'b10,
    TS_MSB_NEG         = 2'b11
  } term_sel_t;

  function automatic int sel_w(input int vl);
    return $clog2(vl) + 1;
  endfunction

  function automatic int sum_w(input int dw, input int vl);
    return dw + $clog2(vl);
  endfunction

  function automatic int acc_w(input int sw, input int wb);
    return sw + wb + 6;
  endfunction

  function automatic int cidx_w(input int wb);
    return $clog2(wb);
  endfunction

endpackage

// File: rtl/mac_vert_col_datapath.sv
// Column datapath: S1 activation select, S2 adder tree, term mux,
// shifters and the special (sum_act * const + hamming) term.
module mac_vert_col_datapath
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int NUM_SEL       = VEC_LENGTH / 2,
  parameter int W_BITS        = 8,
  parameter int SEL_WIDTH     = sel_w(VEC_LENGTH),
  parameter int SUM_ACT_WIDTH = sum_w(DATA_WIDTH, VEC_LENGTH),
  parameter int ACC_WIDTH     = acc_w(SUM_ACT_WIDTH, W_BITS),
  parameter int CW            = cidx_w(W_BITS)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  flush,
  input  logic                                  col_hs,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  input  logic signed [SUM_ACT_WIDTH-1:0]       sum_act,
  input  logic [NUM_SEL-1:0][SEL_WIDTH-1:0]     act_sel,
  input  logic [SEL_WIDTH-1:0]                  hamming_sel,
  input  logic                                  hamming_sign,
  input  logic [2:0]                            mul_const,
  input  logic                                  is_shift_mul,
  input  logic                                  is_skip_zero,
  input  logic [CW-1:0]                         col_idx,
  output logic                                  s1_valid,
  output logic                                  s2_valid,
  output logic signed [ACC_WIDTH-1:0]           term,
  output logic signed [ACC_WIDTH-1:0]           special
);

  localparam int IW = $clog2(VEC_LENGTH);
  localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(VEC_LENGTH);

  logic [NUM_SEL-1:0][DATA_WIDTH-1:0] lane_d, lane_q;
  logic [DATA_WIDTH-1:0] ham_d, ham_q;
  logic sign_q, shift_q, skip_q;
  logic [2:0] mc_q;
  logic [CW-1:0] idx_q;

  // Out-of-range selects read as zero
  always_comb begin
    lane_d = '0;
    ham_d  = '0;
    for (int l = 0; l < NUM_SEL; l++) begin
      if (act_sel[l] < SEL_MAX) lane_d[l] = act[act_sel[l][IW-1:0]];
    end
    if (hamming_sel < SEL_MAX) ham_d = act[hamming_sel[IW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      lane_q   <= '0;
      ham_q    <= '0;
      sign_q   <= 1'b0;
      shift_q  <= 1'b0;
      skip_q   <= 1'b0;
      mc_q     <= '0;
      idx_q    <= '0;
    end else begin
      s1_valid <= col_hs;
      if (col_hs) begin
        lane_q  <= lane_d;
        ham_q   <= ham_d;
        sign_q  <= hamming_sign;
        shift_q <= is_shift_mul;
        skip_q  <= is_skip_zero;
        mc_q    <= mul_const;
        idx_q   <= col_idx;
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] psum, sa, pick_t, prod, ham_x;
  logic signed [ACC_WIDTH-1:0] term_d, special_d;
  logic signed [DATA_WIDTH:0]  ham_n;
  term_sel_t ts;

  always_comb begin
    psum = '0;
    for (int l = 0; l < NUM_SEL; l++) begin
      psum = psum + ACC_WIDTH'($signed(lane_q[l]));
    end
    sa = ACC_WIDTH'(sum_act);
    ts = term_sel_t'({idx_q == CW'(W_BITS - 1), skip_q});
    pick_t = psum;
    unique case (ts)
      TS_ONES_FROM_ZEROS: pick_t = sa - psum;
      TS_PSUM:            pick_t = psum;
      TS_MSB_ZEROS:       pick_t = psum - sa;
      TS_MSB_NEG:         pick_t = -psum;
      default:            pick_t = psum;
    endcase
    prod = sa * ACC_WIDTH'($signed({1'b0, mc_q}));
    if (shift_q) prod = prod <<< 3;
    // One extra bit so negating the most negative activation cannot wrap
    ham_n = {ham_q[DATA_WIDTH-1], ham_q};
    if (sign_q) ham_n = -ham_n;
    ham_x     = ACC_WIDTH'(ham_n);
    term_d    = pick_t <<< idx_q;
    special_d = prod + (ham_x <<< idx_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      term     <= '0;
      special  <= '0;
    end else begin
      s2_valid <= s1_valid & ~flush;
      if (s1_valid) begin
        term    <= term_d;
        special <= special_d;
      end
    end
  end

endmodule

// File: rtl/mac_unit_vert_seq.sv
// Self-sequencing vertical bit-column MAC: FSM, column counter,
// latched activations, accumulator and result handshake. Option: MAC_VERT_SAT_EN.
module mac_unit_vert_seq
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int NUM_SEL       = VEC_LENGTH / 2,
  parameter int W_BITS        = 8,
  parameter int SEL_WIDTH     = sel_w(VEC_LENGTH),
  parameter int SUM_ACT_WIDTH = sum_w(DATA_WIDTH, VEC_LENGTH),
  parameter int ACC_WIDTH     = acc_w(SUM_ACT_WIDTH, W_BITS)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  flush,
  input  logic                                  act_valid,
  output logic                                  act_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  input  logic signed [SUM_ACT_WIDTH-1:0]       sum_act,
  input  logic                                  col_valid,
  output logic                                  col_ready,
  input  logic [NUM_SEL-1:0][SEL_WIDTH-1:0]     act_sel,
  input  logic [SEL_WIDTH-1:0]                  hamming_sel,
  input  logic                                  hamming_sign,
  input  logic [2:0]                            mul_const,
  input  logic                                  is_shift_mul,
  input  logic                                  is_skip_zero,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [ACC_WIDTH-1:0]           result
`ifdef MAC_VERT_SAT_EN
  ,
  output logic                                  sat_flag
`endif
);

  localparam int CW = cidx_w(W_BITS);
  localparam logic [CW-1:0] LAST = CW'(W_BITS - 1);

  state_t state, state_nx;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
  logic signed [SUM_ACT_WIDTH-1:0] sum_q;
  logic [CW-1:0] col_idx;
  logic signed [ACC_WIDTH-1:0] acc, acc_nx, term, special;
  logic s1_valid, s2_valid;
  logic act_hs, col_hs, acc_en;

  assign act_ready = state == IDLE;
  assign col_ready = state == RUN;
  assign out_valid = state == DONE;
  assign act_hs    = act_valid & act_ready & ~flush;
  assign col_hs    = col_valid & col_ready & ~flush;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (act_hs) state_nx = RUN;
      RUN:     if (col_hs && col_idx == '0) state_nx = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  mac_vert_col_datapath #(
    .DATA_WIDTH    (DATA_WIDTH),
    .VEC_LENGTH    (VEC_LENGTH),
    .NUM_SEL       (NUM_SEL),
    .W_BITS        (W_BITS),
    .SEL_WIDTH     (SEL_WIDTH),
    .SUM_ACT_WIDTH (SUM_ACT_WIDTH),
    .ACC_WIDTH     (ACC_WIDTH),
    .CW            (CW)
  ) u_dp (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .col_hs       (col_hs),
    .act          (act_q),
    .sum_act      (sum_q),
    .act_sel      (act_sel),
    .hamming_sel  (hamming_sel),
    .hamming_sign (hamming_sign),
    .mul_const    (mul_const),
    .is_shift_mul (is_shift_mul),
    .is_skip_zero (is_skip_zero),
    .col_idx      (col_idx),
    .s1_valid     (s1_valid),
    .s2_valid     (s2_valid),
    .term         (term),
    .special      (special)
  );

`ifdef MAC_VERT_SAT_EN
  localparam logic signed [ACC_WIDTH+1:0] WMAX =
    (ACC_WIDTH+2)'({1'b0, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH+1:0] WMIN = -WMAX - 1;

  logic signed [ACC_WIDTH+1:0] wide;
  logic sat_hit;

  always_comb begin
    wide = (ACC_WIDTH+2)'(acc) + (ACC_WIDTH+2)'(term)
         + (ACC_WIDTH+2)'(special);
    sat_hit = 1'b1;
    if (wide > WMAX) acc_nx = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else if (wide < WMIN) acc_nx = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else begin
      acc_nx  = wide[ACC_WIDTH-1:0];
      sat_hit = 1'b0;
    end
  end

  // Once clipped, the accumulator is frozen for the rest of the vector
  assign acc_en = s2_valid & ~flush & ~sat_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_flag <= 1'b0;
    else if (act_hs) sat_flag <= 1'b0;
    else if (acc_en && sat_hit) sat_flag <= 1'b1;
  end
`else
  assign acc_nx = acc + term + special;
  assign acc_en = s2_valid & ~flush;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      act_q   <= '0;
      sum_q   <= '0;
      col_idx <= LAST;
      acc     <= '0;
      result  <= '0;
    end else begin
      state <= state_nx;
      if (act_hs) begin
        act_q   <= act;
        sum_q   <= sum_act;
        acc     <= '0;
        col_idx <= LAST;
      end else begin
        if (col_hs) col_idx <= col_idx - CW'(1);
        if (acc_en) acc <= acc_nx;
      end
      if (state == DRAIN && state_nx == DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Scoreboard bench for mac_unit_vert_seq with directed vectors.
// Build with MAC_VERT_SAT_EN to also exercise a narrow saturating instance.
module tb_mac_unit_vert_seq;

  localparam int DW  = 8;
  localparam int VL  = 32;
  localparam int NS  = 16;
  localparam int WB  = 8;
  localparam int SW  = 6;
  localparam int SAW = 13;
  localparam int AW  = 27;

  logic clk = 1'b0;
  logic reset_n, flush, act_valid, act_ready, col_valid, col_ready;
  logic [VL-1:0][DW-1:0] act;
  logic signed [SAW-1:0] sum_act;
  logic [NS-1:0][SW-1:0] act_sel;
  logic [SW-1:0] hamming_sel;
  logic hamming_sign, is_shift_mul, is_skip_zero, out_valid, out_ready;
  logic [2:0] mul_const;
  logic signed [AW-1:0] result;
`ifdef MAC_VERT_SAT_EN
  logic sat_flag, act_ready_s, col_ready_s, out_valid_s, sat_flag_s;
  logic signed [15:0] result_s;
`endif

  always #5 clk = ~clk;

  mac_unit_vert_seq dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .act_valid(act_valid), .act_ready(act_ready),
    .act(act), .sum_act(sum_act),
    .col_valid(col_valid), .col_ready(col_ready),
    .act_sel(act_sel), .hamming_sel(hamming_sel),
    .hamming_sign(hamming_sign), .mul_const(mul_const),
    .is_shift_mul(is_shift_mul), .is_skip_zero(is_skip_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef MAC_VERT_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

`ifdef MAC_VERT_SAT_EN
  mac_unit_vert_seq #(.ACC_WIDTH(16)) u_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .act_valid(act_valid), .act_ready(act_ready_s),
    .act(act), .sum_act(sum_act),
    .col_valid(col_valid), .col_ready(col_ready_s),
    .act_sel(act_sel), .hamming_sel(hamming_sel),
    .hamming_sign(hamming_sign), .mul_const(mul_const),
    .is_shift_mul(is_shift_mul), .is_skip_zero(is_skip_zero),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .sat_flag(sat_flag_s)
  );
`endif

  typedef struct {
    logic [NS-1:0][SW-1:0] sel;
    logic [SW-1:0] hsel;
    logic hsign;
    logic [2:0] mc;
    logic sh;
    logic sz;
  } col_t;

  col_t cols [WB];
  logic [VL-1:0][DW-1:0] act_v;
  logic signed [SAW-1:0] sum_v;
  logic signed [AW-1:0] exp_q [$];
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got %0d expected none", result);
      end else begin
        logic signed [AW-1:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          n_err++;
          $display("FAIL result: got %0d expected %0d", result, e);
        end
      end
    end
  end

  task automatic clear_cols();
    for (int k = 0; k < WB; k++) begin
      for (int l = 0; l < NS; l++) cols[k].sel[l] = SW'(VL);
      cols[k].hsel  = SW'(VL);
      cols[k].hsign = 1'b0;
      cols[k].mc    = 3'd0;
      cols[k].sh    = 1'b0;
      cols[k].sz    = 1'b1;
    end
  endtask

  task automatic ramp_act();
    for (int i = 0; i < VL; i++) act_v[i] = DW'(i);
    sum_v = 13'sd496;
  endtask

  task automatic send_act();
    bit ok;
    ok = 0;
    act = act_v;
    sum_act = sum_v;
    act_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (act_ready) ok = 1;
    end
    if (!ok) chk("act_handshake_timeout", 0, 1);
    @(posedge clk);
    #1 act_valid = 1'b0;
  endtask

  task automatic drive_col(input int k);
    act_sel      = cols[k].sel;
    hamming_sel  = cols[k].hsel;
    hamming_sign = cols[k].hsign;
    mul_const    = cols[k].mc;
    is_shift_mul = cols[k].sh;
    is_skip_zero = cols[k].sz;
    col_valid    = 1'b1;
  endtask

  task automatic send_col(input int k);
    bit ok;
    ok = 0;
    drive_col(k);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (col_ready) ok = 1;
    end
    if (!ok) chk("col_handshake_timeout", 0, 1);
    @(posedge clk);
    #1 col_valid = 1'b0;
  endtask

  task automatic run_vec(input logic signed [AW-1:0] exp, input bit gaps);
    exp_q.push_back(exp);
    send_act();
    for (int k = WB - 1; k >= 0; k--) begin
      send_col(k);
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; flush = 1'b0; act_valid = 1'b0; col_valid = 1'b0;
    out_ready = 1'b1; act = '0; sum_act = '0;
    act_sel = '0; hamming_sel = '0; hamming_sign = 1'b0;
    mul_const = '0; is_shift_mul = 1'b0; is_skip_zero = 1'b0;
    act_v = '0; sum_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_act_ready", act_ready, 1);
    chk("rst_col_ready", col_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single lane in column 0, then column 3 with bubbles
    ramp_act(); clear_cols();
    cols[0].sel[0] = 6'd5;
    run_vec(27'sd5, 1'b0);
    wait_drain();
    clear_cols();
    cols[3].sel[0] = 6'd5;
    run_vec(27'sd40, 1'b1);
    wait_drain();

    // All selects out of range
    for (int i = 0; i < VL; i++) act_v[i] = 8'd1;
    sum_v = 13'sd32; clear_cols();
    run_vec(27'sd0, 1'b0);
    wait_drain();

    // Negated most-negative hamming activation
    act_v = '0; act_v[0] = 8'h80; sum_v = -13'sd128; clear_cols();
    cols[0].hsel = 6'd0; cols[0].hsign = 1'b1;
    run_vec(27'sd128, 1'b0);
    wait_drain();

    // Asynchronous reset in the middle of RUN
    ramp_act(); clear_cols();
    cols[7].sel[0] = 6'd9; cols[6].sel[0] = 6'd9;
    send_act();
    for (int k = WB - 1; k > WB - 4; k--) send_col(k);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_act_ready", act_ready, 1);
    chk("async_rst_col_ready", col_ready, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back columns with collector back-pressure
    ramp_act(); clear_cols();
    cols[7].sel[0] = 6'd1; cols[7].sel[1] = 6'd2;
    cols[6].sz = 1'b0; cols[6].sel[0] = 6'd4;
    cols[2].mc = 3'd2; cols[2].sh = 1'b1;
    cols[0].sel[0] = 6'd31;
    out_ready = 1'b0;
    run_vec(27'sd39071, 1'b0);
    lat = 0;
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", lat, 4);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t4_hold_result", result, 27'sd39071);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_act_ready", act_ready, 0);
    end
`ifdef MAC_VERT_SAT_EN
    chk("sat_result", result_s, 16'sd32767);
    chk("sat_flag", sat_flag_s, 1);
    chk("sat_ctrl", {act_ready_s, col_ready_s, out_valid_s}, 3'b001);
    chk("nosat_flag", sat_flag, 0);
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_act_ready_after", act_ready, 1);
    chk("t4_out_valid_after", out_valid, 0);
    @(posedge clk);
    #1;

    // Flush on column 4, then a clean vector
    ramp_act(); clear_cols();
    for (int k = 0; k < WB; k++) cols[k].sel[0] = 6'd31;
    send_act();
    for (int k = WB - 1; k > WB - 4; k--) send_col(k);
    drive_col(4);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    col_valid = 1'b0;
    @(negedge clk);
    chk("flush_act_ready", act_ready, 1);
    chk("flush_col_ready", col_ready, 0);
    chk("flush_keeps_result", result, 27'sd39071);
    @(posedge clk);
    #1;
    clear_cols();
    cols[7].sz = 1'b0; cols[7].sel[0] = 6'd31;
    cols[3].hsel = 6'd10;
    cols[0].sel[0] = 6'd5;
    run_vec(-27'sd59435, 1'b0);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
